// File: rtl/ring_pkg.sv
// ring_pkg: shared types and helpers for the ring phase monitor.
//   ring_state_t : monitor FSM states (SYNC, TRACK, FAULT)
//   rotl1        : rotate a w-bit value (held in the low bits of a 64-bit word) left by one
//   is_onehot    : true when exactly one bit of the argument is set
// Helpers work on a 64-bit container so one definition serves any ring width up to 64.
package ring_pkg;

  localparam int unsigned RING_MAX_W = 64;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } ring_state_t;

  // Bits at and above position w must be zero on entry; they stay zero on exit.
  function automatic logic [RING_MAX_W-1:0] rotl1(input logic [RING_MAX_W-1:0] v,
                                                  input int unsigned w);
    logic [RING_MAX_W-1:0] mask;
    mask = (w >= RING_MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
    return ((v << 1) | (v >> (w - 1))) & mask;
  endfunction

  function automatic logic is_onehot(input logic [RING_MAX_W-1:0] v);
    return (v != '0) && ((v & (v - 64'd1)) == '0);
  endfunction

endpackage

// File: rtl/onehot_encoder.sv
// onehot_encoder: combinational one-hot to binary index encoder.
//   onehot : WIDTH-bit input vector
//   idx    : index of the set bit (OR of indices of all set bits if not one-hot)
//   valid  : 1 when exactly one bit of onehot is set
module onehot_encoder #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);
  import ring_pkg::*;

  logic [RING_MAX_W-1:0] onehot_ext;

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot[i]) idx = idx | IDX_W'(i);
    end
  end

  always_comb begin
    onehot_ext = '0;
    onehot_ext[WIDTH-1:0] = onehot;
  end

  assign valid = is_onehot(onehot_ext);

endmodule

// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor: checks and decodes the one-hot output of a ring counter.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   ring_q       : ring counter output; ring_en : enable fed to the ring counter
//   resync       : drop lock and reacquire; clr_err : clear sticky error / leave FAULT
//   phase_idx    : binary index of the active ring bit (valid while phase_valid)
//   phase_valid  : high while tracking a legal sequence
//   rev_tick     : one-cycle pulse per 7->0 wrap; rev_count : completed revolutions
//   err_onehot   : pulse, ring_q not one-hot in TRACK
//   err_seq      : pulse, ring_q one-hot but not the expected next value in TRACK
//   err_sticky   : latched OR of both error pulses
//   state_dbg    : current FSM state (ring_state_t encoding) for observation
// Build option: define RING_PHASE_MON_REV_CNT_EN to build the revolution counter;
// when undefined rev_tick and rev_count are constant 0.
module ring_phase_monitor #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int REV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ring_q,
  input  logic             ring_en,
  input  logic             resync,
  input  logic             clr_err,
  output logic [IDX_W-1:0] phase_idx,
  output logic             phase_valid,
  output logic             rev_tick,
  output logic [REV_W-1:0] rev_count,
  output logic             err_onehot,
  output logic             err_seq,
  output logic             err_sticky,
  output logic [1:0]       state_dbg
);
  import ring_pkg::*;

  ring_state_t           state;
  logic [WIDTH-1:0]      prev_q;
  logic                  en_d;
  logic [RING_MAX_W-1:0] prev_ext;
  logic [WIDTH-1:0]      exp_q;
  logic [IDX_W-1:0]      cur_idx;
  logic                  cur_onehot;
  logic                  seq_ok;
  logic                  err_set;

  onehot_encoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc (
    .onehot (ring_q),
    .idx    (cur_idx),
    .valid  (cur_onehot)
  );

  // Expected ring value at this edge: rotated if the counter was enabled last cycle.
  always_comb begin
    prev_ext = '0;
    prev_ext[WIDTH-1:0] = prev_q;
    exp_q = en_d ? WIDTH'(rotl1(prev_ext, WIDTH)) : prev_q;
  end

  assign seq_ok    = cur_onehot && (ring_q == exp_q);
  // resync overrides the TRACK check, so a counter reset bracketed by resync is not an error.
  assign err_set   = (state == TRACK) && !resync && !seq_ok;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= SYNC;
      prev_q      <= '0;
      en_d        <= 1'b0;
      phase_idx   <= '0;
      phase_valid <= 1'b0;
      err_onehot  <= 1'b0;
      err_seq     <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      prev_q     <= ring_q;
      en_d       <= ring_en;
      err_onehot <= 1'b0;
      err_seq    <= 1'b0;

      if (resync) begin
        state       <= SYNC;
        phase_valid <= 1'b0;
      end else begin
        case (state)
          SYNC: begin
            // Lock edge: no comparison, phase_valid rises on the next legal edge.
            phase_valid <= 1'b0;
            if (cur_onehot) state <= TRACK;
          end
          TRACK: begin
            if (!cur_onehot) begin
              err_onehot  <= 1'b1;
              phase_valid <= 1'b0;
              state       <= FAULT;
            end else if (ring_q != exp_q) begin
              err_seq     <= 1'b1;
              phase_valid <= 1'b0;
              state       <= FAULT;
            end else begin
              phase_valid <= 1'b1;
              phase_idx   <= cur_idx;
            end
          end
          FAULT: begin
            phase_valid <= 1'b0;
            if (clr_err) state <= SYNC;
          end
          default: begin
            phase_valid <= 1'b0;
            state       <= SYNC;
          end
        endcase
      end

      // A new error wins over a simultaneous clear.
      if (err_set) err_sticky <= 1'b1;
      else if (clr_err) err_sticky <= 1'b0;
    end
  end

`ifdef RING_PHASE_MON_REV_CNT_EN
  logic wrap;

  // Count only legal wraps seen while tracking.
  assign wrap = (state == TRACK) && !resync && seq_ok && en_d && prev_q[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rev_tick  <= 1'b0;
      rev_count <= '0;
    end else begin
      rev_tick <= wrap;
      if (wrap) rev_count <= rev_count + REV_W'(1);
    end
  end
`else
  assign rev_tick  = 1'b0;
  assign rev_count = '0;
`endif

endmodule

// File: doc/ring_phase_monitor.md
# ring_phase_monitor

Checker and decoder that sits directly downstream of the 8-bit ring counter. It samples the counter's one-hot output `q` and the counter's `enable` every cycle, then encodes the active bit to a binary phase index. It verifies that every transition is a legal single-step rotation or a hold, and counts completed revolutions. The phase index feeds slot-select logic, and the error flags feed the status register.

## Interface
- `WIDTH`, 8: ring width; must be ≥2 and a power of two.
- `IDX_W`, `$clog2(WIDTH)`: phase index width (derived; do not override).
- `REV_W`, 16: revolution counter width.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ring_q`  in  `WIDTH`  ring counter output.
- `ring_en`  in  1  the same `enable` driven into the ring counter.
- `resync`  in  1  single-cycle request to drop lock and reacquire.
- `clr_err`  in  1  clears the sticky error and releases the FAULT state.
- `phase_idx`  out  `IDX_W`  index of the set bit in `ring_q`; valid while `phase_valid`=1.
- `phase_valid`  out  1  high only in TRACK.
- `rev_tick`  out  1  one-cycle pulse on each wrap from bit `WIDTH-1` to bit 0.
- `rev_count`  out  `REV_W`  number of completed revolutions; wraps modulo 2^`REV_W`.
- `err_onehot`  out  1  one-cycle pulse: `ring_q` is not one-hot while in TRACK.
- `err_seq`  out  1  one-cycle pulse: `ring_q` is one-hot but not the expected value while in TRACK.
- `err_sticky`  out  1  latched OR of both error pulses.

## Operation
- Internal registers:
  - `prev_q`: `ring_q` sampled at the previous edge.
  - `en_d`: `ring_en` sampled at the previous edge.
- Expected value at the current edge:
  - If `en_d`=1: rotl(`prev_q`, 1), i.e. {`prev_q[WIDTH-2:0]`, `prev_q[WIDTH-1]`}.
  - If `en_d`=0: `prev_q`.
- State machine: SYNC, TRACK, FAULT. Reset state is SYNC.
- SYNC:
  - If `ring_q` is one-hot, go to TRACK.
  - Otherwise, stay in SYNC.
  - No error flags are raised in SYNC.
- TRACK:
  - If `ring_q` is not one-hot: pulse `err_onehot`, go to FAULT.
  - Else if `ring_q` ≠ expected: pulse `err_seq`, go to FAULT.
  - Otherwise: stay in TRACK and update `phase_idx`.
  - If `en_d`=1 and `prev_q[WIDTH-1]`=1, pulse `rev_tick` and increment `rev_count`.
- FAULT:
  - `phase_valid`=0 and `phase_idx` holds its last value.
  - `clr_err`=1 moves the block to SYNC.
- `resync`=1 in any state forces SYNC on the next edge.
  - Priority: `rst_n` > `resync` > all other transitions.
  - `resync` does not change `err_sticky` or `rev_count`.
- `err_sticky` is set by either error pulse and cleared by `clr_err`. If both occur on the same edge, set wins.
- `clr_err` in SYNC or TRACK clears `err_sticky` only; it does not change state.
- A reset of the ring counter while in TRACK (`ring_q` jumps to bit 0) is flagged as `err_seq`. Software asserts `resync` around any counter reset.

## Timing
- All outputs are registered.
- Every output reflects the `ring_q` value sampled at edge N, and is visible after edge N.
- Reset values (`rst_n`=0 at an edge): state=SYNC, `prev_q`=0, `en_d`=0, `phase_idx`=0, and `phase_valid`, `rev_tick`, `rev_count`, `err_onehot`, `err_seq`, `err_sticky` all 0.
- Lock acquisition: the first edge that sees a one-hot `ring_q` in SYNC moves to TRACK. `phase_valid`=1 from the following edge, so latency is 2 edges.
  - The comparison is skipped on the lock edge. `prev_q` and `en_d` are loaded on every edge in every state.
- `rev_tick` and the `rev_count` increment are coincident.
  - Without saturation, `rev_count` wraps from 2^`REV_W`−1 to 0.
- A hold (`en_d`=0) with one-hot `ring_q` unchanged is legal indefinitely.

## Configuration
- `RING_PHASE_MON_REV_CNT_EN` defined: the revolution counter and `rev_tick` are built as described.
- `RING_PHASE_MON_REV_CNT_EN` undefined: no counter flops are instantiated, `rev_count` is tied to 0, and `rev_tick` is tied to 0. All other behaviour is identical.

## Structure
- The shared package `ring_pkg` holds:
  - The state enum typedef (SYNC, TRACK, FAULT).
  - Function `rotl1`.
  - Function `is_onehot`.
- One sub-module, `onehot_encoder`: combinational. Takes `WIDTH` bits and produces `idx` (`IDX_W` bits) and `valid` (exactly one bit set).

## Test plan
- Reset, then drive `ring_q`=00000001 with `ring_en`=0 → `phase_valid`=1 two edges later, `phase_idx`=0, all error flags 0.
- Lock, then set `ring_en`=1 and rotate the ring for 16 cycles:
  - `phase_idx` steps 0→7→0→7.
  - `rev_tick` pulses on the 10000000→00000001 wrap.
  - `rev_count`=2.
- In TRACK, drive 00000011 → `err_onehot` pulses once, `err_sticky`=1, `phase_valid`=0. Pulse `clr_err` → SYNC, `err_sticky`=0, relock.
- In TRACK with `ring_q`=00000100, `ring_en`=1, next value 00010000 → `err_seq` pulses. The same value repeated with `ring_en`=0 → no error.
- In TRACK, pulse `resync` on the same edge that `ring_q` jumps to 00000001 → no error, relock, `rev_count` unchanged.
- With the macro undefined, rotate for 32 cycles → `rev_count`=0 and `rev_tick`=0 throughout. Apply `rst_n`=0 mid-TRACK → all outputs 0 after that edge.
